// File: rtl/proc_pkg.sv
// Shared types and constants for the ProjectB instruction-sequencing controller.
// Opcode and state encodings, ALU selects and instruction field positions.
package proc_pkg;

  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam int DA_HI = 11;
  localparam int DA_LO = 4;
  localparam int RA_HI = 11;
  localparam int RA_LO = 8;
  localparam int RB_HI = 7;
  localparam int RB_LO = 4;
  localparam int RW_HI = 3;
  localparam int RW_LO = 0;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'h0,
    OP_STORE = 4'h1,
    OP_LOAD  = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_HALT  = 4'h5
  } opcode_t;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

endpackage

// File: rtl/instr_reg.sv
// Instruction register: async clear, loads only when the sequencer fetches,
// so address fields stay stable through every execute state.
module instr_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] ir_q;

  // Capture the ROM word on a fetch cycle; clear zeroes it at once.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      ir_q <= '0;
    end else if (ld_i) begin
      ir_q <= d_i;
    end
  end

  assign q_o = ir_q;

endmodule

// File: rtl/proc_control_unit.sv
// Instruction-sequencing FSM: drives the PC, latches the IR, decodes the
// opcode and issues Moore control strobes to data memory, RF and ALU.
module proc_control_unit
  import proc_pkg::*;
#(
  parameter int IR_W      = 16,
  parameter int D_ADDR_W  = 8,
  parameter int RF_ADDR_W = 4,
  parameter int ALU_SEL_W = 3
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic [IR_W-1:0]      instr,
  output logic                 pc_up,
  output logic                 pc_clear,
  output logic [IR_W-1:0]      ir,
  output logic [D_ADDR_W-1:0]  d_addr,
  output logic                 d_wr,
  output logic                 rf_s,
  output logic [RF_ADDR_W-1:0] rf_w_addr,
  output logic                 rf_w_en,
  output logic [RF_ADDR_W-1:0] rf_ra_addr,
  output logic                 rf_ra_en,
  output logic [RF_ADDR_W-1:0] rf_rb_addr,
  output logic                 rf_rb_en,
  output logic [ALU_SEL_W-1:0] alu_s,
  output logic [3:0]           state,
  output logic                 halted
);

  state_t          state_q;
  state_t          state_d;
  logic            ir_ld;
  logic [IR_W-1:0] ir_q;
  logic [3:0]      op;

  instr_reg #(
    .W (IR_W)
  ) u_ir (
    .clk   (clk),
    .clear (clear),
    .ld_i  (ir_ld),
    .d_i   (instr),
    .q_o   (ir_q)
  );

  assign op         = ir_q[OP_HI:OP_LO];
  assign ir         = ir_q;
  assign state      = state_q;
  assign d_addr     = ir_q[DA_HI:DA_LO];
  assign rf_w_addr  = ir_q[RW_HI:RW_LO];
  assign rf_rb_addr = ir_q[RB_HI:RB_LO];

  // State register; clear aborts any instruction immediately.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Sequencing: fetch, decode, one or two execute states, back to fetch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        unique case (op)
          OP_STORE: state_d = S_STORE;
          OP_LOAD:  state_d = S_LOAD_A;
          OP_ADD:   state_d = S_ADD;
          OP_SUB:   state_d = S_SUB;
          OP_HALT:  state_d = S_HALT;
          default:  state_d = S_NOOP;
        endcase
      end
      S_NOOP:   state_d = S_FETCH;
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B: state_d = S_FETCH;
      S_STORE:  state_d = S_FETCH;
      S_ADD:    state_d = S_FETCH;
      S_SUB:    state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_INIT;
    endcase
  end

  // Moore strobes; port A reads the store source for STORE, else Ra.
  always_comb begin
    pc_up      = 1'b0;
    pc_clear   = 1'b0;
    ir_ld      = 1'b0;
    d_wr       = 1'b0;
    rf_s       = 1'b0;
    rf_w_en    = 1'b0;
    rf_ra_en   = 1'b0;
    rf_rb_en   = 1'b0;
    alu_s      = ALU_PASS;
    halted     = 1'b0;
    rf_ra_addr = ir_q[RA_HI:RA_LO];
    unique case (state_q)
      S_INIT:   pc_clear = 1'b1;
      S_FETCH: begin
        pc_up = 1'b1;
        ir_ld = 1'b1;
      end
      S_LOAD_A: rf_s = 1'b1;
      S_LOAD_B: begin
        rf_s    = 1'b1;
        rf_w_en = 1'b1;
      end
      S_STORE: begin
        rf_ra_addr = ir_q[RW_HI:RW_LO];
        rf_ra_en   = 1'b1;
        d_wr       = 1'b1;
      end
      S_ADD: begin
        rf_ra_en = 1'b1;
        rf_rb_en = 1'b1;
        alu_s    = ALU_ADD;
        rf_w_en  = 1'b1;
      end
      S_SUB: begin
        rf_ra_en = 1'b1;
        rf_rb_en = 1'b1;
        alu_s    = ALU_SUB;
        rf_w_en  = 1'b1;
      end
      S_HALT:   halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/proc_control_unit.md
Name: proc_control_unit

Overview:
- Instruction-sequencing FSM for the ProjectB processor.
- Drives the program counter (up/clear) and latches each fetched instruction into an internal IR.
- Decodes the opcode and issues per-cycle control to data memory, register file and ALU.
- Sits between the instruction ROM/PC pair and the datapath; one instance per processor.

Parameters:
- IR_W, 16, instruction width. Format fixed: [15:12] opcode.
- D_ADDR_W, 8, data-memory address width, taken from IR[11:4].
- RF_ADDR_W, 4, register-file address width.
- ALU_SEL_W, 3, ALU function select width.

Ports:
- clk  in  1  system clock, all state changes on rising edge.
- clear  in  1  reset; asynchronous, active-high. Forces INIT, zeroes the IR.
- instr  in  IR_W  instruction-ROM read data for the current PC address; valid during FETCH.
- pc_up  out  1  PC increment enable.
- pc_clear  out  1  synchronous PC clear request.
- ir  out  IR_W  latched instruction, for display and debug.
- d_addr  out  D_ADDR_W  data-memory address.
- d_wr  out  1  data-memory write enable.
- rf_s  out  1  RF write-data mux select: 1 = data memory, 0 = ALU.
- rf_w_addr  out  RF_ADDR_W  RF write address.
- rf_w_en  out  1  RF write enable.
- rf_ra_addr  out  RF_ADDR_W  RF read port A address.
- rf_ra_en  out  1  RF read port A enable.
- rf_rb_addr  out  RF_ADDR_W  RF read port B address.
- rf_rb_en  out  1  RF read port B enable.
- alu_s  out  ALU_SEL_W  ALU function: 000 pass A, 001 add, 010 sub.
- state  out  4  current state encoding, for 7-seg display.
- halted  out  1  high while in HALT.

Behaviour:
- Opcodes: 0000 NOOP, 0001 STORE, 0010 LOAD, 0011 ADD, 0100 SUB, 0101 HALT. Codes 0110–1111 execute as NOOP.
- Field use per opcode:
  - STORE: RF[IR[3:0]] -> D[IR[11:4]].
  - LOAD: D[IR[11:4]] -> RF[IR[3:0]].
  - ADD/SUB: Ra = IR[11:8], Rb = IR[7:4], Rw = IR[3:0].
- States: INIT, FETCH, DECODE, NOOP, LOAD_A, LOAD_B, STORE, ADD, SUB, HALT.
- Outputs are Moore on state plus IR fields. Every strobe is 0 except as listed per state.
- INIT: pc_clear=1. Next state FETCH.
- FETCH: pc_up=1, IR <= instr at the clock edge. Next state DECODE.
- DECODE: no strobes. Next state by opcode; unknown opcode -> NOOP.
- NOOP: no strobes. -> FETCH.
- LOAD_A: d_addr=IR[11:4], rf_s=1. -> LOAD_B.
- LOAD_B: d_addr held, rf_s=1, rf_w_addr=IR[3:0], rf_w_en=1. -> FETCH.
- STORE: d_addr=IR[11:4], rf_ra_addr=IR[3:0], rf_ra_en=1, d_wr=1. -> FETCH.
- ADD / SUB:
  - rf_ra_addr=IR[11:8], rf_rb_addr=IR[7:4], both read enables=1.
  - alu_s=001 (ADD) or 010 (SUB), rf_s=0, rf_w_addr=IR[3:0], rf_w_en=1.
  - -> FETCH.
- HALT: halted=1. Stays in HALT until clear; pc_up is never asserted.
- Instruction cost: 3 cycles for NOOP/STORE/ADD/SUB, 4 cycles for LOAD (FETCH + DECODE + execute).
- Reset values (clear=1): state=INIT, IR=0, and all outputs at INIT values (pc_clear=1, all else 0). Address fields read 0 because IR=0.
- Reset mid-instruction: aborts immediately, with no partial write. Write strobes drop asynchronously with clear.
- PC wrap 127->0 belongs to the counter. The controller keeps fetching across the wrap.
- Back-to-back instructions: IR changes only in FETCH, so address fields stay stable through all execute states.

Decomposition:
- Package proc_pkg holds:
  - opcode_t enum (4-bit).
  - state_t enum (4-bit; INIT=0 … HALT=9, in the order listed).
  - ALU_PASS/ALU_ADD/ALU_SUB constants.
  - Field-slice localparams.
- One sub-module: instr_reg. IR_W-bit register with async clear and load enable, driven by ir_ld from the FSM.

Test Plan:
- Reset: clear=1 for 2 cycles, then release -> state=INIT with pc_clear=1 for 1 cycle; FETCH next cycle with pc_up=1; ir=0000.
- LOAD, instr=16'h2A53 -> DECODE, then LOAD_A with d_addr=8'hA5, rf_s=1, rf_w_en=0. LOAD_B: rf_w_addr=3, rf_w_en=1. Then FETCH; 4 cycles total.
- ADD, instr=16'h3127 -> ADD state: ra=1, rb=2, rw=7, alu_s=001, rf_w_en=1, rf_s=0. SUB 16'h4127 gives the same with alu_s=010.
- STORE, instr=16'h1FF4 -> d_addr=8'hFF, rf_ra_addr=4, d_wr=1 for exactly 1 cycle.
- HALT and unknown opcode:
  - 16'h5000 -> halted=1 and pc_up=0 for 20+ cycles; clear returns to INIT.
  - 16'hE000 -> NOOP path, no strobes, back to FETCH.
- Reset mid-operation: assert clear during LOAD_B -> rf_w_en falls before the next edge, state=INIT, ir=0.
